// File: rtl/sram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : sram_arb_pkg
// Brief    : Shared types and constants for the SRAM port-0 arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package sram_arb_pkg;

   // Wipe sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WIPE = 1'b1
   } wipe_state_e;

   // Requester identifiers, used for the round-robin last-grant flag
   typedef enum logic {
      REQ_HOST = 1'b0,
      REQ_WIPE = 1'b1
   } req_id_e;

   // Pin levels of an idle (no-operation) command
   localparam logic IDLE_CSB = 1'b1;
   localparam logic IDLE_WEB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_wipe_seq.sv
//------------------------------------------------------------------------------
// Module   : sram_wipe_seq
// Brief    : Secure-wipe sequencer. Walks every SRAM address once per start
//            pulse, requesting one write per address from the arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_wipe_seq
   import sram_arb_pkg::*;
#(
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          gnt,
   output logic          req,
   output logic [AW-1:0] addr,
   output logic          busy,
   output logic          done
);

   wipe_state_e   state;
   wipe_state_e   state_nxt;
   logic [AW-1:0] cnt;
   logic          term_gnt;

   // The grant for the highest address ends the wipe
   assign term_gnt = (state == ST_WIPE) && gnt && (cnt == {AW{1'b1}});

   assign req  = (state == ST_WIPE);
   assign busy = (state == ST_WIPE);
   assign addr = cnt;

   // Next-state logic: a start pulse while wiping is ignored
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)    state_nxt = ST_WIPE;
         ST_WIPE: if (term_gnt) state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Address counter: cleared on start, advanced once per granted wipe write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if ((state == ST_IDLE) && start) begin
         cnt <= '0;
      end else if ((state == ST_WIPE) && gnt) begin
         cnt <= cnt + {{(AW-1){1'b0}}, 1'b1};
      end
   end

   // Done pulses in the cycle the last wipe command reaches the pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done <= 1'b0;
      else        done <= term_gnt;
   end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : sram_port_arbiter
// Brief    : Round-robin arbiter sharing SRAM port 0 between the host write
//            path and the secure-wipe sequencer; all port-0 pins registered.
//            Build option SRAM_WIPE_LOCK_EN: host is locked out while a wipe
//            is busy, so the wipe runs uncontested.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            host_req_i,
   input  logic [AW-1:0]   host_addr_i,
   input  logic [DW-1:0]   host_din_i,
   input  logic [DW/8-1:0] host_mask_i,
   output logic            host_gnt_o,
   input  logic            wipe_start_i,
   input  logic [DW-1:0]   trng_buffer_i,
   output logic            wipe_busy_o,
   output logic            wipe_done_o,
   output logic            sram_csb_o,
   output logic            sram_web_o,
   output logic [DW/8-1:0] sram_mask_o,
   output logic [AW-1:0]   sram_addr_o,
   output logic [DW-1:0]   sram_din_o
);

   localparam int MW = DW / 8;

   logic          host_pend;
   logic          wipe_req;
   logic          wipe_gnt;
   logic [AW-1:0] wipe_addr;
   req_id_e       last_grant;

   // Host is never granted while reset is asserted
`ifdef SRAM_WIPE_LOCK_EN
   assign host_pend = wb_rst_ni & host_req_i & ~wipe_busy_o;
`else
   assign host_pend = wb_rst_ni & host_req_i;
`endif

   // Round-robin: on contention the requester not granted last time wins
   assign host_gnt_o = host_pend && (!wipe_req || (last_grant == REQ_WIPE));
   assign wipe_gnt   = wipe_req  && (!host_pend || (last_grant == REQ_HOST));

   sram_wipe_seq #(
      .AW (AW)
   ) u_wipe_seq (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .start (wipe_start_i),
      .gnt   (wipe_gnt),
      .req   (wipe_req),
      .addr  (wipe_addr),
      .busy  (wipe_busy_o),
      .done  (wipe_done_o)
   );

   // Remember who was granted most recently; resets to wipe so host wins first
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni)      last_grant <= REQ_WIPE;
      else if (host_gnt_o) last_grant <= REQ_HOST;
      else if (wipe_gnt)   last_grant <= REQ_WIPE;
   end

   // Port-0 command registers: load the granted command, else issue a no-op
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sram_csb_o  <= 1'b1;
         sram_web_o  <= 1'b1;
         sram_mask_o <= '0;
         sram_addr_o <= '0;
         sram_din_o  <= '0;
      end else if (host_gnt_o) begin
         sram_csb_o  <= 1'b0;
         sram_web_o  <= 1'b0;
         sram_mask_o <= host_mask_i;
         sram_addr_o <= host_addr_i;
         sram_din_o  <= host_din_i;
      end else if (wipe_gnt) begin
         sram_csb_o  <= 1'b0;
         sram_web_o  <= 1'b0;
         sram_mask_o <= {MW{1'b1}};
         sram_addr_o <= wipe_addr;
         sram_din_o  <= trng_buffer_i;
      end else begin
         sram_csb_o  <= IDLE_CSB;
         sram_web_o  <= IDLE_WEB;
      end
   end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbiter and sequencer for the single read/write port (port 0) of the 512x32 byte-masked SRAM macro. It shares that port between two requesters: the host write path from `user_proj_example`, and an internal secure-wipe engine that overwrites every word with TRNG data from `trng_buffer_o`. It sits between the user project and the SRAM macro, and drives all port-0 command pins from registers.

## Interface
- `AW`, 9, SRAM address width; depth is 2**AW words.
- `DW`, 32, data width; byte mask width is DW/8.
- `wb_clk_i` in 1: sole clock; also clocks SRAM clk0.
- `wb_rst_ni` in 1: asynchronous active-low reset.
- `host_req_i` in 1: host write request; held until granted.
- `host_addr_i` in AW: host write address.
- `host_din_i` in DW: host write data.
- `host_mask_i` in DW/8: host byte-enable mask.
- `host_gnt_o` out 1: combinational; high in the cycle the host command is accepted.
- `wipe_start_i` in 1: single-cycle pulse that starts a full-array wipe.
- `trng_buffer_i` in DW: random word; sampled for each wipe write.
- `wipe_busy_o` out 1: registered; high while a wipe is in progress.
- `wipe_done_o` out 1: registered; one-cycle pulse when a wipe completes.
- `sram_csb_o` out 1: registered chip select, active-low.
- `sram_web_o` out 1: registered write enable, active-low.
- `sram_mask_o` out DW/8: registered write mask.
- `sram_addr_o` out AW: registered address.
- `sram_din_o` out DW: registered write data.

## Operation
- Wipe FSM states are IDLE and WIPE.
  - IDLE -> WIPE on `wipe_start_i`; the address counter clears to 0.
  - WIPE -> IDLE when the write to address 2**AW-1 is granted.
  - `wipe_start_i` during WIPE is ignored; the wipe does not restart.
- While in WIPE, the wipe requester is pending continuously.
  - Each granted wipe write uses address = counter, data = `trng_buffer_i` as sampled that cycle, mask = all ones.
  - The counter increments by 1 on each wipe grant. It never wraps inside a wipe; the terminal grant exits WIPE.
- Arbitration is evaluated each cycle.
  - Exactly one requester pending: that requester is granted.
  - Both pending: round-robin; the grant goes to the requester not granted most recently. The last-grant flag resets to "wipe", so the host wins the first contention.
  - Neither pending: idle command (csb=1, web=1; addr, din and mask hold their previous values).
- Granted command: next cycle's output registers load csb=0, web=0, plus that command's address, data and mask.
- Reset values: `sram_csb_o`=1, `sram_web_o`=1, `sram_mask_o`=0, `sram_addr_o`=0, `sram_din_o`=0, `wipe_busy_o`=0, `wipe_done_o`=0, FSM=IDLE, counter=0.
- Reset asserted mid-wipe: the wipe is abandoned with no `wipe_done_o` pulse. Words already written stay overwritten.

## Timing
- A request granted in cycle N drives the SRAM pins from cycle N+1. The macro captures the write on the edge that ends cycle N+1.
- `host_gnt_o` is combinational from `host_req_i`, arbiter state and FSM state. The host may drop or change its request in the cycle after the grant.
- Uncontested wipe: 2**AW consecutive write commands.
  - `wipe_busy_o` is high from the cycle after the start pulse through the cycle of the last grant.
  - `wipe_done_o` pulses in the cycle after the last grant, coincident with the last command on the pins.
- A fully contested wipe takes at most 2*2**AW cycles. The host waits at most 1 cycle between grants.

## Configuration
- `SRAM_WIPE_LOCK_EN` defined: while `wipe_busy_o`=1, `host_gnt_o` is forced to 0. Host requests stall until the wipe completes, and the wipe runs uncontested in exactly 2**AW cycles.
- `SRAM_WIPE_LOCK_EN` undefined: round-robin sharing as specified above.

## Structure
- Package `sram_arb_pkg` holds:
  - the wipe FSM state enum (IDLE, WIPE);
  - the requester-id enum (HOST, WIPE);
  - the idle-command constants (csb=1, web=1).
- Sub-module `sram_wipe_seq` contains the FSM, address counter, busy/done flags and terminal-count detect. It exposes req/gnt/addr to the arbiter in `sram_port_arbiter`.

## Test plan
- Reset with `host_req_i`=1 held -> all outputs at reset values, `host_gnt_o`=0 while `wb_rst_ni`=0.
- Host write, addr 0x005, data 0xDEADBEEF, mask 0x3, no wipe -> `host_gnt_o` high one cycle. Next cycle: csb=0, web=0, addr=0x005, din=0xDEADBEEF, mask=0x3.
- Wipe start with no host traffic and `trng_buffer_i` incrementing -> 512 consecutive writes to addresses 0..511 with mask 0xF. `wipe_done_o` pulses once, with the addr=511 command. Reading back via port 1 returns the sampled TRNG words.
- Host requesting continuously during a wipe (lock undefined) -> grants alternate host, wipe, host, ...; the wipe finishes in 1024 cycles. With the lock macro defined: no host grant until after `wipe_done_o`, wipe finishes in 512 cycles.
- Second `wipe_start_i` at counter=100 -> ignored; the sequence continues to 511 and produces a single done pulse.
- `wb_rst_ni` asserted at counter=200 -> busy drops immediately, csb=1, no done pulse. A new start after reset begins at address 0.
